// File: rtl/dtw_axil_regfile_if.sv
// dtw_axil_regfile_if: AXI4-Lite channel bundle between the interconnect and the regfile.
interface dtw_axil_regfile_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/dtw_axil_regfile.sv
// dtw_axil_regfile: AXI4-Lite register file fronting the DTW compute core.
// Map: 0 CTRL (bit0 START w1, bit1 IRQ_EN), 1 STATUS (bit0 BUSY, bit1 DONE w1c),
// 2 RESULT (ro), 3..NUM_REGS-1 CFG (rw, byte strobes).
// Optional define DTW_AXIL_ADDR_ERR_EN: out-of-range accesses answer SLVERR.
module dtw_axil_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  dtw_axil_regfile_if.slave                   s_axi,
  output logic                                core_start,
  input  logic                                core_busy,
  input  logic                                core_done,
  input  logic [DATA_WIDTH-1:0]               core_result,
  output logic [(NUM_REGS-3)*DATA_WIDTH-1:0]  cfg_regs,
  output logic                                irq
);

  localparam int unsigned STRBW = DATA_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(STRBW);
  localparam int unsigned IDXW  = $clog2(NUM_REGS);
  localparam int unsigned NCFG  = NUM_REGS - 3;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef DTW_AXIL_ADDR_ERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  // Held write channel state (AW and W may arrive in any order)
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRBW-1:0]      w_strb;

  // Architectural registers
  logic                  irq_en;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] cfg_mem [NCFG];

  logic                  aw_hs_c, w_hs_c, ar_hs_c;
  logic                  commit_c, wr_ok_c;
  logic                  aw_held_n_c, w_held_n_c, bvalid_n_c, rvalid_n_c;
  logic                  start_c, done_clr_c;
  int unsigned           wr_idx_c, rd_idx_c;
  logic                  rd_ok_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  unused_c;

  // In range: index below NUM_REGS and no address bits set above the index field
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] hi;
    hi = a >> (LSB + IDXW);
    return (hi == '0) && (32'(a[LSB +: IDXW]) < NUM_REGS);
  endfunction

  // Write-side handshakes, commit decode and next-state of held flags
  always_comb begin
    aw_hs_c     = s_axi.awvalid & s_axi.awready;
    w_hs_c      = s_axi.wvalid & s_axi.wready;
    commit_c    = aw_held & w_held;
    wr_ok_c     = commit_c & addr_ok(aw_addr);
    wr_idx_c    = 32'(aw_addr[LSB +: IDXW]);
    aw_held_n_c = !commit_c & (aw_held | aw_hs_c);
    w_held_n_c  = !commit_c & (w_held | w_hs_c);
    bvalid_n_c  = commit_c | (s_axi.bvalid & !s_axi.bready);
    start_c     = wr_ok_c && (wr_idx_c == 0) && w_strb[0] && w_data[0] && !core_busy;
    done_clr_c  = wr_ok_c && (wr_idx_c == 1) && w_strb[0] && w_data[1];
  end

  // Read-side handshake and register read mux
  always_comb begin
    ar_hs_c    = s_axi.arvalid & s_axi.arready;
    rvalid_n_c = ar_hs_c | (s_axi.rvalid & !s_axi.rready);
    rd_ok_c    = addr_ok(s_axi.araddr);
    rd_idx_c   = 32'(s_axi.araddr[LSB +: IDXW]);
    rd_data_c  = '0;
    if (rd_ok_c) begin
      if (rd_idx_c == 0) begin
        rd_data_c[1] = irq_en;
      end else if (rd_idx_c == 1) begin
        rd_data_c[1:0] = {done, core_busy};
      end else if (rd_idx_c == 2) begin
        rd_data_c = result;
      end
      for (int unsigned r = 0; r < NCFG; r++) begin
        if (rd_idx_c == r + 3) rd_data_c = cfg_mem[r];
      end
    end
  end

  // Write channel: capture, commit, response, CTRL/CFG update, start pulse
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= RESP_OKAY;
      irq_en        <= 1'b0;
      core_start    <= 1'b0;
      for (int unsigned r = 0; r < NCFG; r++) cfg_mem[r] <= '0;
    end else begin
      aw_held       <= aw_held_n_c;
      w_held        <= w_held_n_c;
      s_axi.bvalid  <= bvalid_n_c;
      s_axi.awready <= !aw_held_n_c & !bvalid_n_c;
      s_axi.wready  <= !w_held_n_c & !bvalid_n_c;
      core_start    <= start_c;
      if (aw_hs_c) aw_addr <= s_axi.awaddr;
      if (w_hs_c) begin
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      if (commit_c) s_axi.bresp <= addr_ok(aw_addr) ? RESP_OKAY : RESP_OOR;
      if (wr_ok_c && (wr_idx_c == 0) && w_strb[0]) irq_en <= w_data[1];
      for (int unsigned r = 0; r < NCFG; r++) begin
        for (int unsigned b = 0; b < STRBW; b++) begin
          if (wr_ok_c && (wr_idx_c == r + 3) && w_strb[b]) begin
            cfg_mem[r][b*8 +: 8] <= w_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read channel: capture data/response on AR handshake, hold until RREADY
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
    end else begin
      s_axi.rvalid  <= rvalid_n_c;
      s_axi.arready <= !rvalid_n_c;
      if (ar_hs_c) begin
        s_axi.rdata <= rd_data_c;
        s_axi.rresp <= rd_ok_c ? RESP_OKAY : RESP_OOR;
      end
    end
  end

  // Core side: DONE flag (set beats W1C clear), RESULT capture, interrupt
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      done   <= 1'b0;
      result <= '0;
      irq    <= 1'b0;
    end else begin
      done <= core_done | (done & !done_clr_c);
      if (core_done) result <= core_result;
      irq  <= done & irq_en;
    end
  end

  // Flatten CFG registers, CFG[3] in the LSBs
  always_comb begin
    cfg_regs = '0;
    for (int unsigned r = 0; r < NCFG; r++) begin
      cfg_regs[r*DATA_WIDTH +: DATA_WIDTH] = cfg_mem[r];
    end
  end

  // Protection bits and sub-word address bits carry no meaning here
  assign unused_c = ^{s_axi.awprot, s_axi.arprot, aw_addr[LSB-1:0], s_axi.araddr[LSB-1:0]};

endmodule

// File: tb/tb_dtw_axil_regfile.sv
// tb_dtw_axil_regfile: directed and randomized checks of the AXI4-Lite DTW register file.
module tb_dtw_axil_regfile;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 6;
  localparam int unsigned NR   = 8;
  localparam int unsigned NCFG = NR - 3;
`ifdef DTW_AXIL_ADDR_ERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic                 clk;
  logic                 aresetn;
  logic                 core_start;
  logic                 core_busy;
  logic                 core_done;
  logic [DW-1:0]        core_result;
  logic [NCFG*DW-1:0]   cfg_regs;
  logic                 irq;

  dtw_axil_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dtw_axil_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .ACLK        (clk),
    .ARESETN     (aresetn),
    .s_axi       (bus),
    .core_start  (core_start),
    .core_busy   (core_busy),
    .core_done   (core_done),
    .core_result (core_result),
    .cfg_regs    (cfg_regs),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;

  // Count high cycles of the start pulse
  always @(negedge clk) if (core_start === 1'b1) start_cnt++;

  // Reference model: architectural state only
  logic [31:0] m_cfg [NR];
  logic        m_irq_en;
  logic        m_done;
  logic [31:0] m_result;
  int          m_starts = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_cfg[i] = 32'h0;
    m_irq_en = 1'b0;
    m_done   = 1'b0;
    m_result = 32'h0;
  endtask

  function automatic logic [31:0] model_read(input int unsigned a);
    int unsigned r;
    r = a / (DW / 8);
    if (r >= NR) return 32'h0;
    case (r)
      0:       return {30'h0, m_irq_en, 1'b0};
      1:       return {30'h0, m_done, core_busy};
      2:       return m_result;
      default: return m_cfg[r];
    endcase
  endfunction

  function automatic logic [1:0] model_resp(input int unsigned a);
    return (a / (DW / 8) >= NR) ? OOR_RESP : 2'b00;
  endfunction

  task automatic model_write(input int unsigned a, input logic [31:0] d, input logic [3:0] s);
    int unsigned r;
    logic [31:0] mask;
    r = a / (DW / 8);
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
    if (r >= NR) return;
    case (r)
      0: if (s[0]) begin
           m_irq_en = d[1];
           if (d[0] && !core_busy) m_starts++;
         end
      1: if (s[0] && d[1]) m_done = 1'b0;
      2: ;
      default: m_cfg[r] = (m_cfg[r] & ~mask) | (d & mask);
    endcase
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_go, w_go;
    int n;
    bus.awaddr = a; bus.awprot = 3'($urandom); bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 20) begin
      aw_go = bus.awvalid & bus.awready;
      w_go  = bus.wvalid & bus.wready;
      @(posedge clk); #1;
      if (aw_go) bus.awvalid = 1'b0;
      if (w_go) bus.wvalid = 1'b0;
      n++;
    end
    while (!bus.bvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bvalid", 64'(bus.bvalid), 64'(1));
    check("bresp", 64'(bus.bresp), 64'(model_resp(a)));
    model_write(a, d, s);
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    logic        ar_go;
    int n;
    exp_d = model_read(a);
    exp_r = model_resp(a);
    bus.araddr = a; bus.arprot = 3'($urandom); bus.arvalid = 1'b1;
    n = 0;
    while (bus.arvalid && n < 20) begin
      ar_go = bus.arvalid & bus.arready;
      @(posedge clk); #1;
      if (ar_go) bus.arvalid = 1'b0;
      n++;
    end
    check("rvalid", 64'(bus.rvalid), 64'(1));
    check("rdata", 64'(bus.rdata), 64'(exp_d));
    check("rresp", 64'(bus.rresp), 64'(exp_r));
    d = bus.rdata;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0; bus.arvalid = 1'b0;
  endtask

  task automatic check_cfg_out(input string tag);
    for (int r = 0; r < NCFG; r++) check(tag, 64'(cfg_regs[r*DW +: DW]), 64'(m_cfg[r+3]));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                    core_start, irq, bus.bresp, bus.rresp}), 64'(0));
    check(tag, 64'(bus.rdata), 64'(0));
    check(tag, 64'(|cfg_regs), 64'(0));
  endtask

  task automatic pulse_done(input logic [31:0] res);
    core_result = res; core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    m_done = 1'b1; m_result = res;
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int s0, n;
    aresetn = 1'b0;
    core_busy = 1'b0; core_done = 1'b0; core_result = '0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Sequential CFG writes 1,2,3... then readback
    for (int i = 3; i < NR; i++) axi_write(AW'(i * 4), 32'(i - 2), 4'hF);
    for (int i = 3; i < NR; i++) begin
      axi_read(AW'(i * 4), d);
      check("cfg_seq_readback", 64'(d), 64'(i - 2));
    end
    check_cfg_out("cfg_out_seq");

    // W two cycles before AW, byte lane 1 only
    axi_write(AW'(12), 32'h0, 4'hF);
    bus.wdata = 32'hAABBCCDD; bus.wstrb = 4'b0010; bus.wvalid = 1'b1; bus.awaddr = AW'(12);
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    @(posedge clk); #1;
    bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    check("w_first_bvalid_early", 64'(bus.bvalid), 64'(0));
    @(posedge clk); #1;
    check("w_first_bvalid", 64'(bus.bvalid), 64'(1));
    check("w_first_bresp", 64'(bus.bresp), 64'(0));
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    model_write(12, 32'hAABBCCDD, 4'b0010);
    axi_read(AW'(12), d);
    check("w_first_readback", 64'(d), 64'h0000CC00);

    // Start pulse, done, irq, W1C
    s0 = start_cnt;
    axi_write(AW'(0), 32'h3, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check("start_one_cycle", 64'(start_cnt - s0), 64'(1));
    pulse_done(32'h1234);
    check("irq_delayed", 64'(irq), 64'(0));
    @(posedge clk); #1;
    check("irq_set", 64'(irq), 64'(1));
    axi_read(AW'(4), d);
    check("status_done", 64'(d), 64'h2);
    axi_read(AW'(8), d);
    check("result_value", 64'(d), 64'h1234);
    axi_write(AW'(8), 32'hFFFFFFFF, 4'hF);
    axi_read(AW'(8), d);
    check("result_ro", 64'(d), 64'h1234);
    axi_write(AW'(4), 32'h2, 4'hF);
    check("irq_cleared", 64'(irq), 64'(0));
    axi_read(AW'(4), d);
    check("status_cleared", 64'(d), 64'h0);

    // Start dropped while busy
    core_busy = 1'b1;
    s0 = start_cnt;
    axi_write(AW'(0), 32'h1, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check("start_busy_dropped", 64'(start_cnt - s0), 64'(0));
    axi_read(AW'(4), d);
    check("status_busy", 64'(d), 64'h1);
    core_busy = 1'b0;

    // DONE set and W1C clear on the same edge: set wins
    pulse_done(32'h77);
    bus.awaddr = AW'(4); bus.wdata = 32'h2; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    core_result = 32'h77; core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    check("collide_bvalid", 64'(bus.bvalid), 64'(1));
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    axi_read(AW'(4), d);
    check("collide_done_kept", 64'(d), 64'h2);
    axi_write(AW'(4), 32'h2, 4'hF);

    // Out-of-range accesses
    axi_read(AW'(NR * 4), d);
    check("oor_rdata", 64'(d), 64'(0));
    check("oor_rresp", 64'(bus.rresp), 64'(OOR_RESP));
    axi_write(AW'(6'h2C), 32'hDEADBEEF, 4'hF);
    check_cfg_out("oor_write_no_effect");

    // Randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom);
      if ($urandom_range(0, 1) == 0) axi_write(a, $urandom, 4'($urandom));
      else axi_read(a, d);
    end
    repeat (2) @(posedge clk);
    #1;
    check("start_count", 64'(start_cnt), 64'(m_starts));
    check_cfg_out("cfg_out_random");

    // Reset while BVALID is pending and BREADY low
    bus.bready = 1'b0;
    bus.awaddr = AW'(20); bus.wdata = 32'h12345678; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 20) begin
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      n++;
    end
    check("pre_reset_bvalid", 64'(bus.bvalid), 64'(1));
    #2;
    aresetn = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    model_reset();
    @(posedge clk); #3;
    aresetn = 1'b1;
    @(posedge clk); #1;
    axi_write(AW'(16), 32'h5A5A5A5A, 4'hF);
    axi_read(AW'(16), d);
    check("post_reset_readback", 64'(d), 64'h5A5A5A5A);
    check_cfg_out("cfg_out_post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
